// File: rtl/mux_serializer_1b.sv
// Parallel-to-serial converter: N-bit word in, one bit per beat out, MSB first, 1-cycle load-to-first-bit latency.
// Optional SER_PARITY_EN appends an even-parity beat after the data beats.
module mux_serializer_1b #(
  parameter int N = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N-1:0]                        data_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_idx,
  output logic                                out_last
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
`ifdef SER_PARITY_EN
  localparam int K_W    = $clog2(N + 1);
  localparam int LAST_K = N;
`else
  localparam int K_W    = CNT_W;
  localparam int LAST_K = N - 1;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       word_q, word_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               out_valid_q, out_valid_d;
  logic               out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;
  logic [N-1:0]       shifted;
  logic               fire_out;
  logic               load;

  assign fire_out  = out_valid_q & out_ready;
  assign in_ready  = (state_q == IDLE) | (fire_out & out_last_q);
  assign load      = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // A reload on the accepted last beat takes priority over returning to IDLE.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    k_d     = k_q;
    if (load) begin
      state_d = SEND;
      word_d  = data_in;
      k_d     = '0;
    end else if (fire_out) begin
      if (out_last_q) begin
        state_d = IDLE;
        k_d     = '0;
      end else begin
        k_d = k_q + K_W'(1);
      end
    end
  end

  // Output registers are loaded from the next beat so every output is a flop.
  always_comb begin
    shifted     = word_d << k_d;
    out_valid_d = (state_d == SEND);
    out_data_d  = 1'b0;
    out_idx_d   = '0;
    out_last_d  = 1'b0;
    if (state_d == SEND) begin
      out_data_d = shifted[N-1];
      out_idx_d  = k_d[CNT_W-1:0];
      out_last_d = (k_d == K_W'(LAST_K));
`ifdef SER_PARITY_EN
      if (k_d == K_W'(N)) begin
        out_data_d = ^word_d;
        out_idx_d  = CNT_W'(N - 1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux_serializer_1b.sv
// Directed bench for mux_serializer_1b (N=4 and N=1 instances) with a bit-reassembling loopback scoreboard.
module tb_mux_serializer_1b;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_data, out_last;
  logic [3:0] data_in;
  logic [1:0] out_idx;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_data1, out_last1;
  logic [0:0] data_in1;
  logic [0:0] out_idx1;
  int         n_chk, n_pass;

  wire [4:0] obs = {out_valid, out_data, out_idx, out_last};

  mux_serializer_1b #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  mux_serializer_1b #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .data_in(data_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #1;
    n_chk++;
    if (obs !== 5'b00000) $display("FAIL reset_outputs: got %b want 00000", obs);
    else n_pass++;
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_chk++;
    if ({out_valid1, out_data1, out_idx1, out_last1} !== 4'b0000)
      $display("FAIL reset_outputs_n1: got %b want 0000", {out_valid1, out_data1, out_idx1, out_last1});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Load one word with out_ready held high and check each beat against a table.
  task automatic test_basic;
`ifdef SER_PARITY_EN
    logic [4:0] exp [0:5];
    exp = '{5'b11000, 5'b10010, 5'b11100, 5'b11110, 5'b11111, 5'b00000};
`else
    logic [4:0] exp [0:4];
    exp = '{5'b11000, 5'b10010, 5'b11100, 5'b11111, 5'b00000};
`endif
    @(negedge clk);
    in_valid = 1'b1; data_in = 4'b1011; out_ready = 1'b1;
    #1;
    n_chk++;
    if (obs !== 5'b00000 || in_ready !== 1'b1)
      $display("FAIL basic_load: got obs=%b rdy=%b want obs=00000 rdy=1", obs, in_ready);
    else n_pass++;
    foreach (exp[i]) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_chk++;
      if (obs !== exp[i]) $display("FAIL basic_beat%0d: got %b want %b", i, obs, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] w;
    logic [4:0] we;
    int         k;
    @(negedge clk);
    in_valid = 1'b1; data_in = 4'hA; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) data_in = 4'h5;
      if (i == 4) in_valid = 1'b0;
      #1;
      w  = (i < 4) ? 4'hA : 4'h5;
      k  = i % 4;
      we = {1'b1, w[3-k], 2'(k), k == 3};
      n_chk++;
      if (obs !== we) $display("FAIL b2b_beat%0d: got %b want %b", i, obs, we);
      else n_pass++;
      n_chk++;
      if (in_ready !== (k == 3)) $display("FAIL b2b_in_ready%0d: got %b want %b", i, in_ready, k == 3);
      else n_pass++;
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (obs !== 5'b00000) $display("FAIL b2b_idle: got %b want 00000", obs);
    else n_pass++;
  endtask

  task automatic test_stall;
    logic       rdy [0:7];
    logic [4:0] exp [0:7];
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp = '{5'b11000, 5'b11010, 5'b11010, 5'b11010, 5'b11010, 5'b10100, 5'b10111, 5'b00000};
    @(negedge clk);
    in_valid = 1'b1; data_in = 4'hC; out_ready = 1'b1;
    foreach (exp[i]) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = rdy[i];
      #1;
      n_chk++;
      if (obs !== exp[i]) $display("FAIL stall_cycle%0d: got %b want %b", i, obs, exp[i]);
      else n_pass++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_word;
    logic [4:0] exp [0:2];
    exp = '{5'b11000, 5'b10010, 5'b10100};
    @(negedge clk);
    in_valid = 1'b1; data_in = 4'h9; out_ready = 1'b1;
    foreach (exp[i]) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_chk++;
      if (obs !== exp[i]) $display("FAIL rstmid_beat%0d: got %b want %b", i, obs, exp[i]);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 5'b00000) $display("FAIL rstmid_async: got %b want 00000", obs);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (obs !== 5'b00000 || in_ready !== 1'b1)
        $display("FAIL rstmid_after%0d: got obs=%b rdy=%b want obs=00000 rdy=1", i, obs, in_ready);
      else n_pass++;
    end
  endtask

  // Random in_valid/out_ready; rebuild each word from beats using out_idx and compare in order.
  task automatic test_loopback(input bit one);
    logic [3:0] q [$];
    logic [3:0] w, rec, exp;
    logic       pend, r, v, d, last, ir;
    logic [1:0] idx;
    int         done, cyc;
    pend = 1'b0; done = 0; cyc = 0; rec = '0; w = '0;
    while (done < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!pend && $urandom_range(0, 4) != 0) begin
        w    = one ? {3'b000, 1'($urandom)} : 4'($urandom);
        pend = 1'b1;
      end
      r = ($urandom_range(0, 3) != 0);
      if (one) begin
        in_valid1 = pend; data_in1 = w[0]; out_ready1 = r;
      end else begin
        in_valid = pend; data_in = w; out_ready = r;
      end
      #1;
      if (one) begin
        ir = in_ready1; v = out_valid1; d = out_data1; idx = {1'b0, out_idx1}; last = out_last1;
      end else begin
        ir = in_ready; v = out_valid; d = out_data; idx = out_idx; last = out_last;
      end
      if (v && r) begin
        if (one) rec = {3'b000, d};
        else rec[3-int'(idx)] = d;
        if (last) begin
          exp = (q.size() > 0) ? q.pop_front() : 4'bxxxx;
          n_chk++;
          if (rec !== exp) $display("FAIL loop%s_word%0d: got %h want %h", one ? "N1" : "N4", done, rec, exp);
          else n_pass++;
          done++;
        end
      end
      if (pend && ir) begin
        q.push_back(w);
        pend = 1'b0;
      end
    end
    n_chk++;
    if (done < 1000) $display("FAIL loop%s_timeout: got %0d words want 1000", one ? "N1" : "N4", done);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1; out_ready1 = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; data_in1 = '0; out_ready1 = 1'b0;
    test_reset();
    test_basic();
`ifndef SER_PARITY_EN
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_loopback(1'b0);
    test_loopback(1'b1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
